// File: rtl/mram_conv_writer.sv
// mram_conv_writer
// Output packer between the Conv2D/MaxPool datapath and MRAM port A.
// Each signed 32-bit accumulator sample is requantized to int8 by
// rounding, arithmetic right shift and saturation. Four bytes are packed
// per word, with lane 0 in bits 7:0. Byte-enabled word writes go to
// sequential addresses starting at a programmed base. A partial last word
// is flushed with only its filled lanes enabled.
//
// Optional build macro:
//   MRAM_WR_RELU_EN - negative requantized results are forced to 0.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            one-cycle job start; ignored unless idle
//   base_addr        first MRAM word address of the job
//   num_bytes        number of int8 outputs in the job
//   shift            requantization right-shift amount (0..31)
//   in_valid/in_data accumulator sample stream
//   in_ready         sample accepted when in_valid & in_ready
//   mram_*_a         MRAM port A write interface (registered)
//   busy             job in progress (PACK/FLUSH)
//   done             one-cycle pulse after the last write
//   words_written    writes issued in the current/last job
//   overflow_err     sticky: address wrapped past the top of MRAM
module mram_conv_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_bytes,
  input  logic [4:0]            shift,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mram_addr_a,
  output logic [DATA_WIDTH-1:0] mram_din_a,
  output logic                  mram_en_a,
  output logic [3:0]            mram_we_a,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  overflow_err
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [1:0]              lane_cnt;
  logic [DATA_WIDTH-1:0]   pack_reg;
  logic [4:0]              shift_r;

  logic                    xfer;
  logic signed [32:0]      acc_ext;
  logic signed [32:0]      round_add;
  logic signed [32:0]      rounded;
  logic [7:0]              q_byte;
  logic [DATA_WIDTH-1:0]   packed_next;
  logic [3:0]              part_mask;

  assign in_ready = (state == PACK) && (remaining != '0);
  assign xfer     = in_valid && in_ready;

  // Requantize in 33 bits so adding the rounding constant to a large
  // positive accumulator cannot wrap negative.
  always_comb begin
    acc_ext   = $signed({in_data[31], in_data});
    round_add = '0;
    if (shift_r != 5'd0) begin
      round_add = 33'sd1 <<< (shift_r - 5'd1);
    end
    rounded = (acc_ext + round_add) >>> shift_r;
    if (rounded > 33'sd127) begin
      q_byte = 8'h7F;
    end else if (rounded < -33'sd128) begin
      q_byte = 8'h80;
    end else begin
      q_byte = rounded[7:0];
    end
`ifdef MRAM_WR_RELU_EN
    if (q_byte[7]) begin
      q_byte = 8'h00;
    end
`else
`endif
  end

  // Word as it looks once the current sample lands in its lane. Lanes
  // above lane_cnt are still zero because pack_reg clears after each word.
  // part_mask enables lanes 0..lane_cnt; for lane_cnt=3 it wraps to 4'b1111.
  always_comb begin
    packed_next = pack_reg;
    packed_next[{lane_cnt, 3'b000} +: 8] = q_byte;
    part_mask = (4'b0010 << lane_cnt) - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      lane_cnt      <= '0;
      pack_reg      <= '0;
      shift_r       <= '0;
      mram_addr_a   <= '0;
      mram_din_a    <= '0;
      mram_en_a     <= 1'b0;
      mram_we_a     <= 4'b0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
      overflow_err  <= 1'b0;
    end else begin
      mram_en_a <= 1'b0;
      mram_we_a <= 4'b0000;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_r       <= shift;
            cur_addr      <= base_addr;
            remaining     <= num_bytes;
            lane_cnt      <= '0;
            pack_reg      <= '0;
            words_written <= '0;
            overflow_err  <= 1'b0;
            if (num_bytes == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PACK;
              busy  <= 1'b1;
            end
          end
        end
        PACK: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            // A word goes out when lane 3 fills or the job's last byte
            // arrives. The write register is separate from pack_reg, so
            // packing of the next word continues without a bubble.
            if ((lane_cnt == 2'd3) || (remaining == 1)) begin
              mram_en_a     <= 1'b1;
              mram_we_a     <= part_mask;
              mram_din_a    <= packed_next;
              mram_addr_a   <= cur_addr;
              cur_addr      <= cur_addr + 1'b1;
              words_written <= words_written + 1'b1;
              if (cur_addr == '1) begin
                overflow_err <= 1'b1;
              end
              pack_reg <= '0;
              lane_cnt <= '0;
              if (lane_cnt != 2'd3) begin
                state <= FLUSH;
              end
            end else begin
              pack_reg <= packed_next;
              lane_cnt <= lane_cnt + 1'b1;
            end
          end else if (remaining == '0) begin
            // Final full-word write is on the bus this cycle.
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mram_conv_writer.sv
// tb_mram_conv_writer
// Directed testbench for mram_conv_writer. A negedge monitor logs every
// MRAM write and done pulse with its cycle number; each test task runs
// one scenario and compares the log against hand-computed values.
module tb_mram_conv_writer;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_bytes;
  logic [4:0]    shift;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic [AW-1:0] mram_addr_a;
  logic [DW-1:0] mram_din_a;
  logic          mram_en_a;
  logic [3:0]    mram_we_a;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
  logic          overflow_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_din[$];
  logic [3:0]    wr_we[$];
  int            wr_cyc[$];
  int            done_cyc[$];

  logic [31:0]   samp[16];
  int            inject_at;
  logic          busy_seen;

  always #5 clk = ~clk;

  mram_conv_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .num_bytes(num_bytes),
    .shift(shift),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mram_addr_a(mram_addr_a),
    .mram_din_a(mram_din_a),
    .mram_en_a(mram_en_a),
    .mram_we_a(mram_we_a),
    .busy(busy),
    .done(done),
    .words_written(words_written),
    .overflow_err(overflow_err)
  );

  always @(negedge clk) begin
    cyc++;
    if (mram_en_a) begin
      wr_addr.push_back(mram_addr_a);
      wr_din.push_back(mram_din_a);
      wr_we.push_back(mram_we_a);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_din.delete();
    wr_we.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  // Start a job and stream samp[0..n-1] back-to-back. If inject_at
  // matches a sample index, a competing start pulse is driven then.
  task automatic run_job(input logic [AW-1:0] b, input logic [LW-1:0] n,
                         input logic [4:0] sh);
    int budget;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_bytes = n; shift = sh;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    for (int i = 0; i < int'(n); i++) begin
      budget = 0;
      while (!in_ready && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      checks++;
      if (budget >= 20) begin
        failures++;
        $display("[TB] FAIL in_ready_timeout: got in_ready=0 at sample %0d, required 1", i);
        break;
      end
      in_valid = 1'b1;
      in_data  = samp[i];
      if (i == inject_at) begin
        start = 1'b1; base_addr = 10'h100; num_bytes = 16'd2;
      end
      @(posedge clk); #1;
      start = 1'b0; base_addr = b; num_bytes = n;
    end
    in_valid = 1'b0;
    budget = 0;
    while (done_cyc.size() == 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      failures++;
      $display("[TB] FAIL done_timeout: got no done pulse, required one");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mram_en_a, mram_we_a, busy, done, in_ready, overflow_err} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got en=%b we=%b busy=%b done=%b rdy=%b ovf=%b, required all 0",
               mram_en_a, mram_we_a, busy, done, in_ready, overflow_err);
    end
    checks++;
    if ({mram_addr_a, mram_din_a, words_written} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got addr=%h din=%h words=%0d, required 0",
               mram_addr_a, mram_din_a, words_written);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    for (int i = 0; i < 8; i++) samp[i] = 32'(i + 1);
    run_job(10'h010, 16'd8, 5'd0);
    checks++;
    if (busy_seen !== 1'b1) begin
      failures++; $display("[TB] FAIL full_busy: got %b, required 1", busy_seen);
    end
    checks++;
    if (wr_addr.size() !== 2) begin
      failures++; $display("[TB] FAIL full_nwr: got %0d, required 2", wr_addr.size());
    end
    checks++;
    if (wr_addr[0] !== 10'h010 || wr_din[0] !== 32'h04030201 || wr_we[0] !== 4'hF) begin
      failures++;
      $display("[TB] FAIL full_wr0: got addr=%h din=%h we=%b, required 010 04030201 1111",
               wr_addr[0], wr_din[0], wr_we[0]);
    end
    checks++;
    if (wr_addr[1] !== 10'h011 || wr_din[1] !== 32'h08070605 || wr_we[1] !== 4'hF) begin
      failures++;
      $display("[TB] FAIL full_wr1: got addr=%h din=%h we=%b, required 011 08070605 1111",
               wr_addr[1], wr_din[1], wr_we[1]);
    end
    checks++;
    if (wr_cyc[1] - wr_cyc[0] !== 4) begin
      failures++; $display("[TB] FAIL full_spacing: got %0d cycles, required 4", wr_cyc[1] - wr_cyc[0]);
    end
    checks++;
    if (done_cyc[0] - wr_cyc[1] !== 1) begin
      failures++; $display("[TB] FAIL full_done_lat: got %0d, required 1", done_cyc[0] - wr_cyc[1]);
    end
    checks++;
    if (words_written !== 11'd2 || overflow_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_status: got words=%0d ovf=%b busy=%b, required 2 0 0",
               words_written, overflow_err, busy);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) samp[i] = 32'h11 + 32'(i);
    run_job(10'h020, 16'd6, 5'd0);
    checks++;
    if (wr_addr.size() !== 2) begin
      failures++; $display("[TB] FAIL flush_nwr: got %0d, required 2", wr_addr.size());
    end
    checks++;
    if (wr_addr[0] !== 10'h020 || wr_din[0] !== 32'h14131211 || wr_we[0] !== 4'hF) begin
      failures++;
      $display("[TB] FAIL flush_wr0: got addr=%h din=%h we=%b, required 020 14131211 1111",
               wr_addr[0], wr_din[0], wr_we[0]);
    end
    checks++;
    if (wr_addr[1] !== 10'h021 || wr_din[1] !== 32'h00001615 || wr_we[1] !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL flush_wr1: got addr=%h din=%h we=%b, required 021 00001615 0011",
               wr_addr[1], wr_din[1], wr_we[1]);
    end
    checks++;
    if (done_cyc[0] - wr_cyc[1] !== 1 || words_written !== 11'd2) begin
      failures++;
      $display("[TB] FAIL flush_done: got lat=%0d words=%0d, required 1 2",
               done_cyc[0] - wr_cyc[1], words_written);
    end
  endtask

  task automatic test_requant();
    logic [31:0] exp_a, exp_b, exp_c;
`ifdef MRAM_WR_RELU_EN
    exp_a = 32'h007F0102; exp_b = 32'h7F000200; exp_c = 32'h00010001;
`else
    exp_a = 32'h807F0102; exp_b = 32'h7F8002FF; exp_c = 32'h0001FF01;
`endif
    samp[0] = 32'd24; samp[1] = 32'd23; samp[2] = 32'd5000; samp[3] = -32'sd5000;
    run_job(10'h030, 16'd4, 5'd4);
    checks++;
    if (wr_din[0] !== exp_a || wr_we[0] !== 4'hF || wr_addr.size() !== 1) begin
      failures++;
      $display("[TB] FAIL requant_sh4: got din=%h we=%b n=%0d, required %h 1111 1",
               wr_din[0], wr_we[0], wr_addr.size(), exp_a);
    end
    samp[0] = -32'sd3; samp[1] = 32'd3; samp[2] = -32'sd256; samp[3] = 32'd255;
    run_job(10'h031, 16'd4, 5'd1);
    checks++;
    if (wr_din[0] !== exp_b) begin
      failures++; $display("[TB] FAIL requant_sh1: got %h, required %h", wr_din[0], exp_b);
    end
    samp[0] = 32'h7FFFFFFF; samp[1] = 32'h80000000; samp[2] = 32'h40000000;
    run_job(10'h032, 16'd3, 5'd31);
    checks++;
    if (wr_din[0] !== exp_c || wr_we[0] !== 4'b0111) begin
      failures++;
      $display("[TB] FAIL requant_sh31: got din=%h we=%b, required %h 0111",
               wr_din[0], wr_we[0], exp_c);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) samp[i] = 32'(i + 1);
    run_job(10'h3FF, 16'd8, 5'd0);
    checks++;
    if (wr_addr[0] !== 10'h3FF || wr_addr[1] !== 10'h000) begin
      failures++;
      $display("[TB] FAIL wrap_addr: got %h %h, required 3ff 000", wr_addr[0], wr_addr[1]);
    end
    checks++;
    if (overflow_err !== 1'b1 || words_written !== 11'd2) begin
      failures++;
      $display("[TB] FAIL wrap_ovf: got ovf=%b words=%0d, required 1 2", overflow_err, words_written);
    end
  endtask

  task automatic test_zero_len();
    run_job(10'h070, 16'd0, 5'd0);
    checks++;
    if (wr_addr.size() !== 0 || done_cyc.size() !== 1) begin
      failures++;
      $display("[TB] FAIL zero_len: got writes=%0d dones=%0d, required 0 1",
               wr_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 5; i++) samp[i] = 32'(i + 1);
    inject_at = 2;
    run_job(10'h040, 16'd5, 5'd0);
    inject_at = -1;
    checks++;
    if (wr_addr.size() !== 2 || wr_addr[0] !== 10'h040 || wr_addr[1] !== 10'h041) begin
      failures++;
      $display("[TB] FAIL ign_addr: got n=%0d %h %h, required 2 040 041",
               wr_addr.size(), wr_addr[0], wr_addr[1]);
    end
    checks++;
    if (wr_din[0] !== 32'h04030201 || wr_din[1] !== 32'h00000005 || wr_we[1] !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL ign_data: got %h %h we=%b, required 04030201 00000005 0001",
               wr_din[0], wr_din[1], wr_we[1]);
    end
    checks++;
    if (words_written !== 11'd2 || overflow_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ign_status: got words=%0d ovf=%b, required 2 0", words_written, overflow_err);
    end
  endtask

  task automatic test_reset_mid_job();
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h050; num_bytes = 16'd8; shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mram_en_a, mram_we_a, busy, done, in_ready, overflow_err} !== 9'd0 ||
        {mram_addr_a, mram_din_a, words_written} !== '0) begin
      failures++;
      $display("[TB] FAIL midrst_outs: got en=%b we=%b busy=%b rdy=%b addr=%h din=%h words=%0d, required all 0",
               mram_en_a, mram_we_a, busy, in_ready, mram_addr_a, mram_din_a, words_written);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== 0) begin
      failures++; $display("[TB] FAIL midrst_nowrite: got %0d writes, required 0", wr_addr.size());
    end
    for (int i = 0; i < 4; i++) samp[i] = 32'h21 + 32'(i);
    run_job(10'h060, 16'd4, 5'd0);
    checks++;
    if (wr_addr[0] !== 10'h060 || wr_din[0] !== 32'h24232221 || words_written !== 11'd1) begin
      failures++;
      $display("[TB] FAIL midrst_restart: got addr=%h din=%h words=%0d, required 060 24232221 1",
               wr_addr[0], wr_din[0], words_written);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0; shift = '0;
    in_valid = 1'b0; in_data = '0; inject_at = -1; busy_seen = 1'b0;
    test_reset();
    test_full_words();
    test_flush();
    test_requant();
    test_wrap();
    test_start_ignored();
    test_zero_len();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mram_conv_writer.md
Name: mram_conv_writer

Overview:
Output packer between the Conv2D/MaxPool datapath and port A of the conv-model MRAM. It accepts a stream of signed 32-bit accumulator results and requantizes each to int8 (round, shift, saturate). It packs four bytes per 32-bit word, little-endian by lane, and issues byte-enabled word writes to sequential MRAM addresses from a programmed base. A partial last word is flushed with only its filled lanes enabled.

Parameters:
ADDR_WIDTH, 10, MRAM word-address width; must match the MRAM instance
DATA_WIDTH, 32, MRAM word width; fixed at 32 (4 byte lanes)
LEN_WIDTH, 16, width of the byte-count field

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches base_addr, num_bytes, shift; ignored while busy
base_addr  input  ADDR_WIDTH  first MRAM word address
num_bytes  input  LEN_WIDTH  number of int8 outputs in the job
shift  input  5  requantization right-shift amount (0..31)
in_valid  input  1  accumulator sample valid
in_data  input  32  signed accumulator sample
in_ready  output  1  block accepts the sample this cycle (transfer = in_valid & in_ready)
mram_addr_a  output  ADDR_WIDTH  MRAM port A word address
mram_din_a  output  DATA_WIDTH  MRAM port A write data
mram_en_a  output  1  MRAM port A enable
mram_we_a  output  4  MRAM port A byte write enables
busy  output  1  job in progress
done  output  1  one-cycle pulse when the last write has been issued
words_written  output  ADDR_WIDTH+1  word writes issued in the current/last job
overflow_err  output  1  sticky: address wrapped past the top of MRAM during the job

Behaviour:
- Reset (synchronous, active-high) forces all outputs to 0, including mram_en_a and mram_we_a. The FSM goes to IDLE and the pack register and lane counter clear. Reset mid-job aborts the job and issues no further write.
- FSM states: IDLE, PACK, FLUSH, DONE.
- IDLE: in_ready=0.
  - start with num_bytes>0: latch the job fields, clear words_written and overflow_err, and go to PACK.
  - start with num_bytes=0: go to DONE and issue no write.
- PACK: in_ready=1 while remaining>0.
  - Each transfer writes the requantized byte into lane[lane_cnt]; lane 0 is bits 7:0. lane_cnt then increments and remaining decrements.
  - Lane 3 filled: on the next cycle, mram_en_a=1, mram_we_a=4'b1111, mram_din_a=the packed word, mram_addr_a=the current address.
  - The packed word moves to a separate write register, so acceptance continues without a bubble (one sample per cycle sustained).
  - Last byte accepted with lane_cnt<3: go to FLUSH.
  - Last byte accepted with lane 3 filled: the full-word write takes the next cycle, then go to DONE.
- FLUSH: one cycle. mram_en_a=1 and mram_we_a has only the filled lanes set (e.g. 2 bytes gives 4'b0011). Unfilled lanes of mram_din_a are 0. Go to DONE.
- DONE: done=1 for one cycle, busy=0 next, return to IDLE. busy=1 in PACK and FLUSH.
- Write cycles: mram_en_a=1 only on write cycles; otherwise mram_en_a=0 and mram_we_a=0. The address increments by 1 after each write.
- Address wrap: from 2^ADDR_WIDTH-1 the address wraps to 0 and overflow_err sets. It stays set until the next accepted start or reset.
- Requantization (per sample):
  - If shift>0, add 2^(shift-1) in 33-bit signed arithmetic, then arithmetic right shift by shift. If shift=0, pass the value unchanged.
  - Saturate to [-128,127]; the byte is the two's-complement int8.
- words_written increments on every issued write, including a partial flush.
- Start pulses arriving in PACK, FLUSH or DONE are ignored.

Optional Feature:
MRAM_WR_RELU_EN
- Defined: after saturation, negative results are forced to 0, so the byte range is [0,127].
- Undefined: signed int8 is stored unchanged.
- All other timing is identical either way.

Test Plan:
- base=0x010, num=8, shift=0; inputs 1..8 back-to-back -> writes addr 0x010 din 0x04030201 we 1111, then addr 0x011 din 0x08070605 we 1111; done one cycle later; words_written=2.
- num=6, shift=0; inputs 0x11..0x16 -> write 0x14131211 at base, then FLUSH din 0x00001615 we 0011 at base+1; words_written=2.
- shift=4; inputs 24, 23, 5000, -5000 -> bytes 0x02, 0x01, 0x7F, 0x80; word 0x807F0102. With MRAM_WR_RELU_EN: 0x007F0102.
- base=0x3FF, num=8 -> first write at 0x3FF, second at 0x000; overflow_err=1 after the second write.
- num=0 start -> done pulse with no mram_en_a assertion. A start pulse while busy is ignored: addresses and count are unchanged.
- Reset asserted after 3 bytes accepted -> no write issued; all outputs 0 on the next cycle; a new job then starts cleanly at its base.
